// File: rtl/exu_alu_seq_pkg.sv
// exu_alu_seq_pkg: ALU control codes, FSM state encodings and op helpers shared by the EX-stage ALU
package exu_alu_seq_pkg;
    localparam logic [3:0] ALU_CTRL_ADD  = 4'd0;
    localparam logic [3:0] ALU_CTRL_SUB  = 4'd1;
    localparam logic [3:0] ALU_CTRL_SLL  = 4'd2;
    localparam logic [3:0] ALU_CTRL_SLT  = 4'd3;
    localparam logic [3:0] ALU_CTRL_SLTU = 4'd4;
    localparam logic [3:0] ALU_CTRL_XOR  = 4'd5;
    localparam logic [3:0] ALU_CTRL_SRL  = 4'd6;
    localparam logic [3:0] ALU_CTRL_SRA  = 4'd7;
    localparam logic [3:0] ALU_CTRL_OR   = 4'd8;
    localparam logic [3:0] ALU_CTRL_AND  = 4'd9;

    typedef enum logic [1:0] {
        EXU_ALU_ST_IDLE  = 2'd0,
        EXU_ALU_ST_SHIFT = 2'd1,
        EXU_ALU_ST_DONE  = 2'd2
    } exu_alu_st_t;

    function automatic logic is_shift(input logic [3:0] c);
        return c == ALU_CTRL_SLL || c == ALU_CTRL_SRL || c == ALU_CTRL_SRA;
    endfunction
endpackage

// File: rtl/exu_alu_seq_comb.sv
// exu_alu_comb: single-cycle ALU ops; unknown codes behave as ADD, word adjust only on ADD/SUB
module exu_alu_comb
    import exu_alu_seq_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            is_word,
    output logic [XLEN-1:0] result
);
    logic [XLEN-1:0] sum;
    logic [XLEN-1:0] diff;
    logic [XLEN-1:0] raw;
    logic            logic_op;

    // Select the operation; anything not a compare or bitwise op is arithmetic and may be word-adjusted
    always_comb begin
        sum      = src1 + src2;
        diff     = src1 - src2;
        logic_op = alu_ctrl == ALU_CTRL_SLT || alu_ctrl == ALU_CTRL_SLTU || alu_ctrl == ALU_CTRL_XOR ||
                   alu_ctrl == ALU_CTRL_OR || alu_ctrl == ALU_CTRL_AND;
        raw      = alu_ctrl == ALU_CTRL_SUB  ? diff :
                   alu_ctrl == ALU_CTRL_SLT  ? {{(XLEN-1){1'b0}}, $signed(src1) < $signed(src2)} :
                   alu_ctrl == ALU_CTRL_SLTU ? {{(XLEN-1){1'b0}}, src1 < src2} :
                   alu_ctrl == ALU_CTRL_XOR  ? src1 ^ src2 :
                   alu_ctrl == ALU_CTRL_OR   ? src1 | src2 :
                   alu_ctrl == ALU_CTRL_AND  ? src1 & src2 : sum;
        result   = is_word && !logic_op ? {{(XLEN-32){raw[31]}}, raw[31:0]} : raw;
    end
endmodule

// File: rtl/exu_alu_seq.sv
// exu_alu_seq: EX-stage ALU with registered single-cycle ops and bit-serial shifts behind valid/ready
module exu_alu_seq
    import exu_alu_seq_pkg::*;
#(
    parameter  int XLEN    = 64,
    localparam int SHAMT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            is_word,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);
    exu_alu_st_t        state;
    exu_alu_st_t        state_nxt;
    logic [XLEN-1:0]    work;
    logic [XLEN-1:0]    work_init;
    logic [XLEN-1:0]    work_step;
    logic [XLEN-1:0]    comb_res;
    logic [SHAMT_W-1:0] cnt;
    logic [SHAMT_W-1:0] shamt;
    logic [3:0]         op;
    logic               word;
    logic               accept;
    logic               last;

    function automatic logic [XLEN-1:0] wadj(input logic w, input logic [XLEN-1:0] v);
        return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
    endfunction

    exu_alu_comb #(.XLEN(XLEN)) u_comb (
        .alu_ctrl (alu_ctrl),
        .src1     (src1),
        .src2     (src2),
        .is_word  (is_word),
        .result   (comb_res)
    );

    // Shift datapath: operand setup at accept and the one-bit step applied each SHIFT cycle
    always_comb begin
        accept    = in_valid && in_ready && !flush;
        last      = cnt == SHAMT_W'(1);
        shamt     = is_word ? {{(SHAMT_W-5){1'b0}}, src2[4:0]} : src2[SHAMT_W-1:0];
        work_init = !is_word ? src1 :
                    alu_ctrl == ALU_CTRL_SRA ? {{(XLEN-32){src1[31]}}, src1[31:0]} :
                                               {{(XLEN-32){1'b0}}, src1[31:0]};
        work_step = op == ALU_CTRL_SLL ? {work[XLEN-2:0], 1'b0} :
                                         {op == ALU_CTRL_SRA && work[XLEN-1], work[XLEN-1:1]};
    end

    // State, result and shift registers; flush clears only the counter and leaves result intact
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= EXU_ALU_ST_IDLE;
            result <= '0;
            cnt    <= '0;
            work   <= '0;
            op     <= '0;
            word   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (flush) begin
                cnt <= '0;
            end else if (accept) begin
                op   <= alu_ctrl;
                word <= is_word;
                if (is_shift(alu_ctrl)) begin
                    work <= work_init;
                    cnt  <= shamt;
                    if (shamt == '0)
                        result <= wadj(is_word, work_init);
                end else begin
                    result <= comb_res;
                end
            end else if (state == EXU_ALU_ST_SHIFT) begin
                work <= work_step;
                cnt  <= cnt - 1'b1;
                if (last)
                    result <= wadj(word, work_step);
            end
        end
    end

    // Next-state: flush wins, a fresh accept restarts the FSM even from DONE, otherwise shift or drain
    always_comb begin
        state_nxt = state;
        if (flush)
            state_nxt = EXU_ALU_ST_IDLE;
        else if (accept)
            state_nxt = is_shift(alu_ctrl) && shamt != '0 ? EXU_ALU_ST_SHIFT : EXU_ALU_ST_DONE;
        else if (state == EXU_ALU_ST_SHIFT)
            state_nxt = last ? EXU_ALU_ST_DONE : EXU_ALU_ST_SHIFT;
        else if (state == EXU_ALU_ST_DONE)
            state_nxt = out_ready ? EXU_ALU_ST_IDLE : EXU_ALU_ST_DONE;
    end

    // Handshake outputs derived purely from state so neither is ever high while shifting
    always_comb begin
        out_valid = state == EXU_ALU_ST_DONE;
        in_ready  = state == EXU_ALU_ST_IDLE || (state == EXU_ALU_ST_DONE && out_ready);
    end
endmodule

// File: tb/tb_exu_alu_seq.sv
// tb_exu_alu_seq: directed vector table plus hand-written backpressure, flush and reset sequences
module tb_exu_alu_seq;
    import exu_alu_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  alu_ctrl = '0;
    logic [63:0] src1 = '0;
    logic [63:0] src2 = '0;
    logic        is_word = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] result;

    int total = 0;
    int passed = 0;

    typedef struct {
        logic [3:0]  ctrl;
        logic [63:0] a;
        logic [63:0] b;
        logic        w;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[19];

    exu_alu_seq #(.XLEN(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .src1      (src1),
        .src2      (src2),
        .is_word   (is_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    endtask

    task automatic start_op(input logic [3:0] c, input logic [63:0] a, input logic [63:0] b, input logic w);
        alu_ctrl = c;
        src1     = a;
        src2     = b;
        is_word  = w;
        in_valid = 1'b1;
    endtask

    initial begin
        int lat;
        int stall_ready;
        logic seen;
        vecs[0]  = '{ALU_CTRL_ADD,  64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1};
        vecs[1]  = '{ALU_CTRL_SUB,  64'd0, 64'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1};
        vecs[2]  = '{ALU_CTRL_SLT,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd1, 1};
        vecs[3]  = '{ALU_CTRL_SLTU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1};
        vecs[4]  = '{ALU_CTRL_SRA,  64'h8000_0000_0000_0000, 64'd63, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64};
        vecs[5]  = '{ALU_CTRL_SRA,  64'h8000_0000_0000_0000, 64'd0, 1'b0, 64'h8000_0000_0000_0000, 1};
        vecs[6]  = '{ALU_CTRL_SRL,  64'hFFFF_FFFF_8000_0000, 64'h21, 1'b1, 64'h0000_0000_4000_0000, 2};
        vecs[7]  = '{ALU_CTRL_XOR,  64'hF0, 64'hFF, 1'b0, 64'h0F, 1};
        vecs[8]  = '{ALU_CTRL_OR,   64'hF0, 64'h0F, 1'b0, 64'hFF, 1};
        vecs[9]  = '{ALU_CTRL_AND,  64'hF0, 64'h3C, 1'b0, 64'h30, 1};
        vecs[10] = '{ALU_CTRL_ADD,  64'h7FFF_FFFF, 64'd1, 1'b1, 64'hFFFF_FFFF_8000_0000, 1};
        vecs[11] = '{ALU_CTRL_SLL,  64'd1, 64'd63, 1'b0, 64'h8000_0000_0000_0000, 64};
        vecs[12] = '{ALU_CTRL_SLL,  64'd1, 64'd31, 1'b1, 64'hFFFF_FFFF_8000_0000, 32};
        vecs[13] = '{ALU_CTRL_SRA,  64'h8000_0000, 64'd4, 1'b1, 64'hFFFF_FFFF_F800_0000, 5};
        vecs[14] = '{4'hF,          64'd2, 64'd3, 1'b0, 64'd5, 1};
        vecs[15] = '{ALU_CTRL_XOR,  64'hFFFF_FFFF_0000_0000, 64'd0, 1'b1, 64'hFFFF_FFFF_0000_0000, 1};
        vecs[16] = '{ALU_CTRL_SLT,  64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'd0, 1};
        vecs[17] = '{ALU_CTRL_SLTU, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'd1, 1};
        vecs[18] = '{ALU_CTRL_SRL,  64'hF000_0000_0000_0000, 64'd4, 1'b0, 64'h0F00_0000_0000_0000, 5};

        repeat (2) @(negedge clk);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset result", result, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 19; i++) begin
            start_op(vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].w);
            @(negedge clk);
            in_valid = 1'b0;
            src1 = 64'hDEAD_BEEF_DEAD_BEEF;
            src2 = 64'h1234_5678_9ABC_DEF0;
            alu_ctrl = ALU_CTRL_AND;
            is_word = ~is_word;
            lat = 1;
            stall_ready = 0;
            while (!out_valid && lat < 200) begin
                if (in_ready) stall_ready++;
                @(negedge clk);
                lat++;
            end
            check($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].lat));
            check($sformatf("vec%0d result", i), result, vecs[i].exp);
            if (vecs[i].lat > 1)
                check($sformatf("vec%0d in_ready while busy", i), 64'(stall_ready), 64'd0);
            @(negedge clk);
        end

        out_ready = 1'b0;
        start_op(ALU_CTRL_XOR, 64'hF0, 64'hFF, 1'b0);
        @(negedge clk);
        start_op(ALU_CTRL_AND, 64'hF0, 64'h3C, 1'b0);
        for (int k = 0; k < 5; k++) begin
            check("stall result", result, 64'h0F);
            check("stall out_valid", 64'(out_valid), 64'd1);
            check("stall in_ready", 64'(in_ready), 64'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        check("release in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("b2b out_valid", 64'(out_valid), 64'd1);
        check("b2b result", result, 64'h30);
        @(negedge clk);
        check("drain out_valid", 64'(out_valid), 64'd0);

        start_op(ALU_CTRL_ADD, 64'd7, 64'd8, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush blocks accept", 64'(out_valid), 64'd0);
        check("flush blocks result", result, 64'h30);

        start_op(ALU_CTRL_SLL, 64'd1, 64'd40, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush in_ready", 64'(in_ready), 64'd1);
        check("flush out_valid", 64'(out_valid), 64'd0);
        check("flush keeps result", result, 64'h30);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen |= out_valid;
        end
        check("flush no late valid", 64'(seen), 64'd0);

        start_op(ALU_CTRL_SLL, 64'd1, 64'd40, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset out_valid", 64'(out_valid), 64'd0);
        check("midreset in_ready", 64'(in_ready), 64'd1);
        check("midreset result", result, 64'd0);
        rst_n = 1'b1;
        start_op(ALU_CTRL_SUB, 64'd10, 64'd3, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        check("post reset out_valid", 64'(out_valid), 64'd1);
        check("post reset result", result, 64'd7);
        @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/exu_alu_seq.md
Name: exu_alu_seq

Overview:
Execute-stage ALU that consumes the 4-bit ALU control code produced by the ID-stage ALU-control decoder, together with two operands.
- Single-cycle ops (ADD/SUB/SLT/SLTU/XOR/OR/AND) produce a registered result with latency 1.
- Shifts (SLL/SRL/SRA) run iteratively, one bit per cycle, to save area.
- Sits between the ID/EX pipeline register and the EX/MEM stage, with valid/ready handshakes on both sides.

Parameters:
- XLEN, 64, operand/result width.
- SHAMT_W, $clog2(XLEN), shift-amount counter width (derived; not overridden).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- flush  input  1  synchronous pipeline flush; abandons any in-flight op.
- in_valid  input  1  request valid.
- in_ready  output  1  unit can accept a request this cycle.
- alu_ctrl  input  4  operation code, one of the ALU_CTRL_* constants.
- src1  input  XLEN  operand 1 (shift source).
- src2  input  XLEN  operand 2 (shift amount in low bits).
- is_word  input  1  RV64 *W variant: 32-bit op, result sign-extended.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- result  output  XLEN  registered result.

Behaviour:
- State machine: IDLE, SHIFT, DONE.
- Reset (rst_n=0 at a rising edge):
  - state=IDLE, out_valid=0, result=0, shift counter=0.
  - in_ready=1 from the first cycle after reset.
  - Reset overrides flush and any handshake, including mid-shift.
- in_ready = (state==IDLE) || (state==DONE && out_ready). The unit accepts on in_valid && in_ready && !flush. Operands and code are captured at accept, so the upstream may change them afterwards.
- Non-shift accept:
  - result <= f(src1, src2); state -> DONE.
  - out_valid rises the next cycle (latency 1).
- Arithmetic:
  - ADD/SUB are modulo 2^XLEN.
  - SLT is a signed compare, SLTU an unsigned compare; both give result 0 or 1, zero-extended.
  - XOR/OR/AND are bitwise.
  - Unknown code executes as ADD.
- Word rules:
  - is_word=1 with ADD/SUB: result = sign-extend of bits [31:0] of the sum/difference.
  - is_word is ignored for SLT/SLTU/XOR/OR/AND (full width).
- Shift accept:
  - shamt = src2[SHAMT_W-1:0], or src2[4:0] when is_word=1.
  - Working register setup when is_word=1: SRA uses sign-extended src1[31:0]; SRL and SLL use zero-extended src1[31:0]. When is_word=0, the working register loads src1 as-is.
  - shamt==0: go straight to DONE; result = working value, word-adjusted.
  - shamt>0: state -> SHIFT, counter = shamt.
- SHIFT:
  - Each cycle the working register shifts one bit: SLL left with 0 fill; SRL right with 0 fill; SRA right with MSB replicate.
  - The counter decrements each cycle. The cycle in which counter==1 performs the final shift, writes result and moves to DONE.
  - Total latency from accept to out_valid = shamt+1 cycles.
  - When is_word=1, the final result = sign-extend of bits [31:0].
- DONE:
  - out_valid=1; result is held stable until out_ready=1.
  - On out_ready with no new accept: -> IDLE, out_valid=0 next cycle.
  - On out_ready with a same-cycle accept: the new op starts with no bubble.
  - out_valid never drops without out_ready, except on flush or reset.
- flush:
  - Applies in any state; next cycle state=IDLE and out_valid=0.
  - result keeps its old value; the counter is cleared.
  - A same-cycle in_valid is not accepted.
- out_valid and in_ready are never asserted in SHIFT.

Decomposition:
- The ALU_CTRL_* operation codes stay in defines.v, shared with the ID stage.
- State encodings (IDLE/SHIFT/DONE) are added to defines.v as EXU_ALU_ST_* constants.
- Sub-module exu_alu_comb: purely combinational ADD/SUB/SLT/SLTU/XOR/OR/AND with word adjust.
- exu_alu_seq contains the FSM, shift datapath, counter and handshake.

Test Plan:
- ADD src1=0x7FFF_FFFF_FFFF_FFFF, src2=1, is_word=0, out_ready=1 -> out_valid exactly 1 cycle after accept, result=0x8000_0000_0000_0000.
- SUB is_word=1, src1=0, src2=1 -> result=0xFFFF_FFFF_FFFF_FFFF; then SLT src1=-1, src2=1 -> result=1; SLTU same operands -> result=0.
- SRA src1=0x8000_0000_0000_0000, src2=63 -> in_ready=0 for 63 cycles, out_valid 64 cycles after accept, result=0xFFFF_FFFF_FFFF_FFFF. Same op with src2=0 -> latency 1, result=src1.
- SRL is_word=1, src1=0xFFFF_FFFF_8000_0000, src2=0x21 -> shamt=1, latency 2, result=0x0000_0000_4000_0000.
- Backpressure:
  - Stimulus: XOR 0xF0 ^ 0xFF with out_ready=0 for 5 cycles, in_valid held high with a new AND.
  - Required while stalled: result=0x0F stable, out_valid=1, in_ready=0.
  - Required on release: the cycle out_ready=1 also accepts the AND (back-to-back), and the AND result is valid the next cycle.
- SLL shamt=40 with flush asserted on the 10th SHIFT cycle -> out_valid never rises, in_ready=1 next cycle. Repeat with rst_n=0 mid-shift -> all outputs at reset values next cycle.
